// File: rtl/uart_rx_param_pkg.sv
// uart_rx_param_pkg: state encoding, line levels and sampling helpers shared by the UART receiver blocks
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } state_t;

  localparam logic B_START = 1'b0;
  localparam logic B_STOP  = 1'b1;
  localparam int   TICK_W  = 5;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// uart_rx_param_sampler: two-flop synchroniser plus 3-tap majority vote over s_tick samples
module uart_rx_param_sampler
  import uart_rx_param_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic s_tick,
  input  logic rx,
  output logic rx_s,
  output logic maj
);

  logic       rx_m;
  logic [1:0] hist;

  // Synchronise rx and keep the two previous tick samples; idle-high reset avoids a false start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      hist <= 2'b11;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (s_tick) hist <= {hist[0], rx_s};
    end
  end

  // Vote over the two stored samples and the sample being taken on this tick
  assign maj = maj3({hist, rx_s});

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with optional parity, 1/2 stop bits, framing and break detection
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam logic [TICK_W-1:0] S_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] S_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        N_LAST = 4'(DATA_BITS - 1);
  localparam logic              K_LAST = 1'(STOP_BITS - 1);

  state_t               state, state_n;
  logic [TICK_W-1:0]    s, s_n;
  logic [3:0]           n, n_n;
  logic                 k, k_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 pbit, pbit_n;
  logic                 sb0, sb0_n;
  logic                 fe_acc, fe_acc_n;
  logic                 done_n;
  logic                 rx_s, maj;
  logic                 first_stop, brk, pe_calc, fe_calc;

  uart_rx_param_sampler u_sampler (
    .clock  (clock),
    .reset_n(reset_n),
    .s_tick (s_tick),
    .rx     (rx),
    .rx_s   (rx_s),
    .maj    (maj)
  );

  // Frame verdicts evaluated while the last stop bit is being sampled
  assign first_stop = k ? sb0 : maj;
  assign brk        = (shreg == '0) && !((PARITY_EN != 0) && pbit) && (first_stop == B_START);
  assign pe_calc    = (PARITY_EN != 0) && (^{shreg, pbit} ^ 1'(PARITY_ODD));
  assign fe_calc    = fe_acc || (maj != B_STOP);

  // Next-state and datapath updates, all advanced only on s_tick
  always_comb begin
    state_n  = state;
    s_n      = s;
    n_n      = n;
    k_n      = k;
    shreg_n  = shreg;
    pbit_n   = pbit;
    sb0_n    = sb0;
    fe_acc_n = fe_acc;
    done_n   = 1'b0;
    if (s_tick) begin
      case (state)
        IDLE: if (rx_s == B_START) begin
          s_n     = '0;
          state_n = START;
        end
        START: if (s == S_MID) begin
          s_n     = '0;
          n_n     = '0;
          state_n = (maj == B_START) ? DATA : IDLE;
        end else s_n = s + 1'b1;
        DATA: if (s == S_LAST) begin
          s_n     = '0;
          shreg_n = {maj, shreg[DATA_BITS-1:1]};
          n_n     = n + 4'd1;
          if (n == N_LAST) begin
            k_n      = 1'b0;
            fe_acc_n = 1'b0;
            state_n  = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end else s_n = s + 1'b1;
        PARITY: if (s == S_LAST) begin
          s_n     = '0;
          pbit_n  = maj;
          state_n = STOP;
        end else s_n = s + 1'b1;
        STOP: if (s == S_LAST) begin
          s_n      = '0;
          k_n      = k + 1'b1;
          sb0_n    = first_stop;
          fe_acc_n = fe_calc;
          if (k == K_LAST) begin
            done_n  = 1'b1;
            state_n = brk ? BRK : IDLE;
          end
        end else s_n = s + 1'b1;
        BRK: if (maj == B_STOP) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; outputs only change when a frame completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      s          <= '0;
      n          <= '0;
      k          <= 1'b0;
      shreg      <= '0;
      pbit       <= 1'b0;
      sb0        <= 1'b0;
      fe_acc     <= 1'b0;
      rx_done    <= 1'b0;
      d_out      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      state   <= state_n;
      s       <= s_n;
      n       <= n_n;
      k       <= k_n;
      shreg   <= shreg_n;
      pbit    <= pbit_n;
      sb0     <= sb0_n;
      fe_acc  <= fe_acc_n;
      rx_done <= done_n;
      if (done_n) begin
        d_out      <= shreg;
        parity_err <= pe_calc;
        frame_err  <= fe_calc;
        break_det  <= brk;
      end
    end
  end

endmodule
